// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Feeds the digit inputs of the 7-segment decoder. 4'hF is emitted on purpose
// for digits that the decoder should blank (overflow, suppressed leading zeros).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; bcd_out/overflow hold the last result
// SHIFT | one add-3/shift step per cycle, IN_WIDTH steps in total
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    // Enough internal digits for 2^IN_WIDTH-1 regardless of DIGITS.
    localparam int INT_DIGITS = (IN_WIDTH + 2) / 3;
    localparam int SR_W       = 4 * INT_DIGITS + IN_WIDTH;
    localparam int MAXD       = (DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS;
    localparam int CNT_W      = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q;
    logic [SR_W-1:0]       sr_q;
    logic [SR_W-1:0]       sr_d;
    logic [SR_W-1:0]       adj;
    logic [CNT_W-1:0]      cnt_q;
    logic [4*DIGITS-1:0]   bcd_d;
    logic                  ovf_d;
    logic [3:0]            ext_dig [MAXD];
    logic                  lead;

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        adj = sr_q;
        for (int k = 0; k < INT_DIGITS; k++) begin
            if (sr_q[IN_WIDTH + 4*k +: 4] >= 4'd5) begin
                adj[IN_WIDTH + 4*k +: 4] = sr_q[IN_WIDTH + 4*k +: 4] + 4'd3;
            end
        end
        sr_d = adj << 1;
    end

    // Result formatting from the post-step register: overflow, width fit, blanking.
    always_comb begin
        for (int k = 0; k < MAXD; k++) begin
            ext_dig[k] = 4'd0;
        end
        for (int k = 0; k < INT_DIGITS; k++) begin
            ext_dig[k] = sr_d[IN_WIDTH + 4*k +: 4];
        end
        ovf_d = 1'b0;
        for (int k = DIGITS; k < MAXD; k++) begin
            if (ext_dig[k] != 4'd0) begin
                ovf_d = 1'b1;
            end
        end
        bcd_d = '0;
        lead  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if ((BLANK_LZ != 0) && lead && (ext_dig[k] == 4'd0) && (k != 0)) begin
                bcd_d[4*k +: 4] = 4'hF;
            end else begin
                bcd_d[4*k +: 4] = ext_dig[k];
                if (ext_dig[k] != 4'd0) begin
                    lead = 1'b0;
                end
            end
        end
        if (ovf_d) begin
            bcd_d = '1;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= {{(4*INT_DIGITS){1'b0}}, bin_in};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bcd_out  <= bcd_d;
                        overflow <= ovf_d;
                        done     <= 1'b1;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: three instances (DIGITS=3, DIGITS=3 with
// leading-zero blanking, DIGITS=2) share clock, reset and stimulus.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;

    logic        busy_a, done_a, valid_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, valid_b, ovf_b;
    logic [11:0] bcd_b;
    logic        busy_c, done_c, valid_c, ovf_c;
    logic [7:0]  bcd_c;

    int n_chk;
    int n_bad;
    int cyc;

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .valid(valid_a), .overflow(ovf_a), .bcd_out(bcd_a)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_d3b (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_b), .done(done_b), .valid(valid_b), .overflow(ovf_b), .bcd_out(bcd_b)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2), .BLANK_LZ(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_c), .done(done_c), .valid(valid_c), .overflow(ovf_c), .bcd_out(bcd_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Waits (at falling edges) for done, counting busy cycles; bounded.
    task automatic wait_done(output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard = 0;
        while (!done_a && guard < 30) begin
            if (busy_a) busy_cycles++;
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", {31'd0, done_a}, 32'd1);
    endtask

    // Pulse start for one cycle with value v, then wait for completion.
    task automatic convert(input logic [7:0] v, output int busy_cycles);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        wait_done(busy_cycles);
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  {31'd0, busy_a},  32'd0);
        chk("rst_done",  {31'd0, done_a},  32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf_c},   32'd0);
        chk("rst_bcd",   {20'd0, bcd_a},   32'h000);
        chk("rst_bcd_b", {20'd0, bcd_b},   32'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // 255: 8 busy cycles, all three formats
        convert(8'd255, cyc);
        chk("busy_cycles_255", cyc, 32'd8);
        chk("d3_255",   {20'd0, bcd_a}, 32'h255);
        chk("d3_255_ovf", {31'd0, ovf_a}, 32'd0);
        chk("d3_255_valid", {31'd0, valid_a}, 32'd1);
        chk("d3b_255",  {20'd0, bcd_b}, 32'h255);
        chk("d2_255",   {24'd0, bcd_c}, 32'hFF);
        chk("d2_255_ovf", {31'd0, ovf_c}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_a}, 32'd0);
        chk("valid_sticky", {31'd0, valid_a}, 32'd1);

        convert(8'd0, cyc);
        chk("d3_0",  {20'd0, bcd_a}, 32'h000);
        chk("d3b_0", {20'd0, bcd_b}, 32'hFF0);
        chk("d2_0",  {24'd0, bcd_c}, 32'h00);
        chk("d2_0_ovf", {31'd0, ovf_c}, 32'd0);
        @(negedge clk);

        convert(8'd7, cyc);
        chk("d3_7",  {20'd0, bcd_a}, 32'h007);
        chk("d3b_7", {20'd0, bcd_b}, 32'hFF7);
        @(negedge clk);

        convert(8'd99, cyc);
        chk("d2_99", {24'd0, bcd_c}, 32'h99);
        chk("d2_99_ovf", {31'd0, ovf_c}, 32'd0);
        chk("d3b_99", {20'd0, bcd_b}, 32'hF99);
        @(negedge clk);

        convert(8'd100, cyc);
        chk("d2_100", {24'd0, bcd_c}, 32'hFF);
        chk("d2_100_ovf", {31'd0, ovf_c}, 32'd1);
        chk("d3_100", {20'd0, bcd_a}, 32'h100);
        chk("d3b_100", {20'd0, bcd_b}, 32'h100);
        @(negedge clk);

        // 42 with a start pulse (value 17) during busy, then back-to-back 17
        start  = 1'b1;
        bin_in = 8'd42;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'd200;
        repeat (2) @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd17;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'd150;
        wait_done(cyc);
        chk("d3_42_ignore", {20'd0, bcd_a}, 32'h042);
        start  = 1'b1;
        bin_in = 8'd17;
        @(negedge clk);
        start  = 1'b0;
        chk("b2b_busy", {31'd0, busy_a}, 32'd1);
        wait_done(cyc);
        chk("d3_17_b2b", {20'd0, bcd_a}, 32'h017);
        chk("b2b_cycles", cyc, 32'd8);
        repeat (4) @(negedge clk);
        chk("hold_bcd", {20'd0, bcd_a}, 32'h017);
        chk("hold_ovf_d2", {31'd0, ovf_c}, 32'd0);

        // Reset mid-conversion
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, busy_a},  32'd0);
        chk("midrst_valid", {31'd0, valid_a}, 32'd0);
        chk("midrst_bcd",   {20'd0, bcd_a},   32'h000);
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, done_a}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", {31'd0, busy_a}, 32'd0);
        convert(8'd5, cyc);
        chk("after_rst_cycles", cyc, 32'd8);
        chk("after_rst_bcd", {20'd0, bcd_a}, 32'h005);
        chk("after_rst_bcd_b", {20'd0, bcd_b}, 32'hFF5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
